// File: rtl/rcon_sequencer.sv
// AES round-constant generator: steps an xtime (doubling) or inverse-xtime
// (halving) register once per consumer advance, in forward or reverse order.
module rcon_sequencer #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B,
  parameter int               RND_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [1:0]       key_mode,
  input  logic             reverse,
  input  logic             advance,
  output logic [WIDTH-1:0] rcon_out,
  output logic [RND_W-1:0] round_num,
  output logic             valid,
  output logic             last,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] r);
    return (r << 1) ^ (r[WIDTH-1] ? POLY : '0);
  endfunction

  // Exact inverse of xtime: undo the reduction when the low bit shows it happened.
  function automatic logic [WIDTH-1:0] xhalf(input logic [WIDTH-1:0] r);
    return r[0] ? (((r ^ POLY) >> 1) | MSB) : (r >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] rcon_at(input int n);
    logic [WIDTH-1:0] v;
    v = ONE;
    for (int i = 1; i < n; i++) v = xtime(v);
    return v;
  endfunction

  localparam logic [WIDTH-1:0] C10 = rcon_at(10);
  localparam logic [WIDTH-1:0] C8  = rcon_at(8);
  localparam logic [WIDTH-1:0] C7  = rcon_at(7);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rcon;
  logic [RND_W-1:0] r_round;
  logic [RND_W-1:0] r_n;
  logic             r_dir;

  logic [RND_W-1:0] w_n;
  logic [WIDTH-1:0] w_crev;
  logic             w_last;

  always_comb begin
    w_n    = RND_W'(10);
    w_crev = C10;
    case (key_mode)
      2'b01: begin w_n = RND_W'(8); w_crev = C8; end
      2'b10: begin w_n = RND_W'(7); w_crev = C7; end
      default: ;
    endcase
  end

  assign w_last = (r_state == RUN) &&
                  (r_dir ? (r_round == RND_W'(1)) : (r_round == r_n));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_rcon  <= '0;
      r_round <= '0;
      r_n     <= RND_W'(10);
      r_dir   <= 1'b0;
    end else if (start) begin
      r_state <= RUN;
      r_n     <= w_n;
      r_dir   <= reverse;
      r_rcon  <= reverse ? w_crev : ONE;
      r_round <= reverse ? w_n : RND_W'(1);
    end else begin
      case (r_state)
        RUN: begin
          if (advance) begin
            if (w_last) begin
              r_state <= DONE;
            end else if (r_dir) begin
              r_rcon  <= xhalf(r_rcon);
              r_round <= r_round - RND_W'(1);
            end else begin
              r_rcon  <= xtime(r_rcon);
              r_round <= r_round + RND_W'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rcon_out  = r_rcon;
  assign round_num = r_round;
  assign valid     = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign last      = w_last;

endmodule

// File: tb/tb_rcon_sequencer.sv
// Bench for rcon_sequencer: directed scenarios plus random stimulus scored
// against a list-based model of the round-constant sequence.
module tb_rcon_sequencer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] key_mode = 2'b00;
  logic       reverse = 1'b0;
  logic       advance = 1'b0;
  logic [7:0] rcon_out;
  logic [3:0] round_num;
  logic       valid, last, done;

  int pass_cnt = 0;
  int tot = 0;

  rcon_sequencer #(.WIDTH(8), .POLY(8'h1B), .RND_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .key_mode(key_mode),
    .reverse(reverse), .advance(advance), .rcon_out(rcon_out),
    .round_num(round_num), .valid(valid), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  wire [14:0] act = {rcon_out, round_num, valid, last, done};

  // Model: the whole sequence as a list, a cursor into it, and held outputs.
  int m_list[$];
  int m_idx, m_n, m_rcon, m_round;
  bit m_valid, m_done, m_dir;

  function automatic void model_reset();
    m_list.delete();
    m_idx = 0; m_n = 10; m_rcon = 0; m_round = 0;
    m_valid = 0; m_done = 0; m_dir = 0;
  endfunction

  function automatic void build(input logic [1:0] km, input bit rv);
    int v;
    m_n = (km == 2'b01) ? 8 : (km == 2'b10) ? 7 : 10;
    m_list.delete();
    v = 1;
    for (int i = 0; i < m_n; i++) begin
      if (rv) m_list.push_front(v); else m_list.push_back(v);
      v = v * 2;
      if (v > 255) v = v ^ 'h11B;
    end
  endfunction

  function automatic void model_step(input bit s, input logic [1:0] km,
                                     input bit rv, input bit adv);
    m_done = 0;
    if (s) begin
      build(km, rv);
      m_dir = rv; m_idx = 0; m_valid = 1;
    end else if (adv && m_valid) begin
      if (m_idx == m_n - 1) begin
        m_valid = 0; m_done = 1;
      end else m_idx++;
    end
    if (m_valid) begin
      m_rcon  = m_list[m_idx];
      m_round = m_dir ? (m_n - m_idx) : (m_idx + 1);
    end
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [7:0] rc;
    logic [3:0] rn;
    rc = 8'(m_rcon);
    rn = 4'(m_round);
    return {rc, rn, m_valid, m_valid && (m_idx == m_n - 1), m_done};
  endfunction

  task automatic tick(input bit s, input logic [1:0] km, input bit rv, input bit adv);
    start = s; key_mode = km; reverse = rv; advance = adv;
    model_step(s, km, rv, adv);
    @(posedge clk);
    #1;
    start = 1'b0; advance = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    tot++;
    if (act !== 15'h0) $display("FAIL reset act=%h exp=%h", act, 15'h0);
    else pass_cnt++;
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd128();
    logic [7:0] tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [14:0] e;
    for (int i = 0; i < 10; i++) begin
      tick(i == 0, 2'b00, 1'b0, i != 0);
      e = {tbl[i], 4'(i + 1), 1'b1, i == 9, 1'b0};
      tot++;
      if (act !== e) $display("FAIL fwd128 step%0d act=%h exp=%h", i, act, e);
      else pass_cnt++;
    end
    tick(1'b0, 2'b00, 1'b0, 1'b1);
    e = {8'h36, 4'd10, 1'b0, 1'b0, 1'b1};
    tot++;
    if (act !== e) $display("FAIL fwd128_done act=%h exp=%h", act, e);
    else pass_cnt++;
    tick(1'b0, 2'b00, 1'b0, 1'b0);
    e = {8'h36, 4'd10, 1'b0, 1'b0, 1'b0};
    tot++;
    if (act !== e) $display("FAIL fwd128_idle act=%h exp=%h", act, e);
    else pass_cnt++;
  endtask

  task automatic test_modes();
    logic [1:0] km [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    bit         rv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int m = 0; m < 4; m++) begin
      tick(1'b1, km[m], rv[m], 1'b0);
      for (int c = 0; c < 12; c++) begin
        tot++;
        if (act !== exp_vec())
          $display("FAIL modes m%0d c%0d act=%h exp=%h", m, c, act, exp_vec());
        else pass_cnt++;
        tick(1'b0, 2'b00, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic test_hold();
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 2'b11, 1'b1, 1'b0);
      tot++;
      if (act !== {8'h08, 4'd4, 3'b100})
        $display("FAIL hold c%0d act=%h exp=%h", i, act, {8'h08, 4'd4, 3'b100});
      else pass_cnt++;
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'b00, 1'b0, 1'b1);
      tot++;
      if (act !== exp_vec() || valid !== 1'b0)
        $display("FAIL adv_idle c%0d act=%h exp=%h", i, act, exp_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_restart();
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 2'b00, 1'b0, 1'b1);
    tot++;
    if (round_num !== 4'd5) $display("FAIL restart_pre act=%0d exp=5", round_num);
    else pass_cnt++;
    tick(1'b1, 2'b00, 1'b0, 1'b1);
    tot++;
    if (act !== {8'h01, 4'd1, 3'b100})
      $display("FAIL restart act=%h exp=%h", act, {8'h01, 4'd1, 3'b100});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 2'b00, 1'b0, 1'b1);
    #3 n_rst = 1'b0;
    #1;
    model_reset();
    tot++;
    if (act !== 15'h0) $display("FAIL async_reset act=%h exp=%h", act, 15'h0);
    else pass_cnt++;
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'b00, 1'b0, 1'b1);
      tot++;
      if (act !== 15'h0) $display("FAIL post_reset c%0d act=%h exp=%h", i, act, 15'h0);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit s, rv, adv;
    logic [1:0] km;
    for (int c = 0; c < 400; c++) begin
      s   = ($urandom_range(0, 19) == 0) || (!m_valid && $urandom_range(0, 3) == 0);
      rv  = 1'($urandom);
      km  = 2'($urandom);
      adv = ($urandom_range(0, 2) != 0);
      tick(s, km, rv, adv);
      tot++;
      if (act !== exp_vec())
        $display("FAIL random c%0d act=%h exp=%h", c, act, exp_vec());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fwd128();
    test_modes();
    test_hold();
    test_restart();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule

// File: doc/rcon_sequencer.md
Name: rcon_sequencer

Overview:
Sequential round-constant generator for the AES key-expansion datapath. It replaces per-round table lookup with an iterated GF(2^WIDTH) doubling or halving register. It supports AES-128/192/256 round counts and forward (encrypt) or reverse (decrypt) ordering. It sits beside the key-expansion FSM, which requests one constant per round through a start/advance handshake.

Parameters:
WIDTH, 8, field/output width in bits
POLY, 8'h1B, reduction polynomial low bits (x^WIDTH term implicit)
RND_W, 4, width of round counter output

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begin a new constant sequence
key_mode  input  2  00=AES-128 (10 rounds), 01=AES-192 (8), 10=AES-256 (7), 11=reserved→treated as 00
reverse  input  1  sampled with start; 0=ascending order, 1=descending order
advance  input  1  consumer has used current constant; step to next
rcon_out  output  WIDTH  current round constant
round_num  output  RND_W  current round index, 1..N
valid  output  1  rcon_out/round_num are meaningful
last  output  1  current constant is the final one of the sequence
done  output  1  one-cycle pulse after the final constant is consumed

Behaviour:
- Reset, asynchronous on n_rst low: rcon_out=0, round_num=0, valid=0, last=0, done=0, internal count N=10, dir=0. Reset mid-sequence aborts immediately; no done pulse.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (n_rst).
- Start, cycle t: on the t+1 edge, latch N from key_mode and dir from reverse.
  - Forward: rcon_out=01, round_num=1.
  - Reverse: rcon_out=C(N), round_num=N, where C(N)=x^(N-1) mod poly, computed at elaboration. Defaults: C(10)=36, C(8)=80, C(7)=40.
  - valid=1 from t+1.
- start has priority over advance in the same cycle. start while valid restarts the sequence and does not pulse done.
- Advance accepted only when valid=1; ignored when valid=0.
- Forward step: rcon_out ← xtime(rcon_out) = (r<<1) ^ (r[MSB] ? POLY : 0), truncated to WIDTH; round_num+1.
- Reverse step: rcon_out ← r[0] ? ((r^POLY)>>1) | MSB-one : r>>1; round_num-1.
- last is combinational from registered state: forward round_num==N, reverse round_num==1.
- Advance while last=1: next edge valid=0, last=0, done=1 for exactly one cycle. rcon_out and round_num hold their final values. No wrap-around.
- States: IDLE(valid=0) →start→ RUN; RUN →advance&!last→ RUN; RUN →advance&last→ DONE; DONE → IDLE after one cycle. start in any state → RUN. done is asserted only in DONE.
- key_mode and reverse are ignored except at start. Changing them mid-sequence has no effect.
- Latency: constant available one cycle after start or advance. Outputs are registered; no input-to-output combinational path except last, which is derived from state only.

Test Plan:
- Reset then start, mode=00, reverse=0, advance every cycle → rcon_out 01,02,04,08,10,20,40,80,1B,36 with round_num 1..10. last=1 only at 36. done pulses one cycle later; valid=0 after.
- Start, mode=00, reverse=1 → 36,1B,80,40,20,10,08,04,02,01 with round_num 10..1. done after 01 is consumed.
- Mode=01 forward → 8 constants ending 80, last at round 8. Mode=10 reverse → starts at 40, 7 constants ending 01. Mode=11 → identical to mode=00.
- Advance held low for 5 cycles mid-sequence at 08 → outputs hold 08/round 4. Advance while valid=0 → no change. start and advance in the same cycle at round 5 → restart to 01/round 1, no done pulse.
- n_rst low asynchronously at round 6 (between edges) → all outputs 0 immediately. After release, no done pulse and valid stays 0 until the next start.
